// File: rtl/spi_flash_arbiter.sv
// -----------------------------------------------------------------------------
// spi_flash_arbiter
//
// Two-requester round-robin arbiter in front of a block-read SPI flash
// controller. The winner of arbitration gets its byte address aligned down to
// a 1024-byte block and sent to the controller with a one-cycle read strobe.
// The FSM then waits for the controller's completion pulse or for a timeout,
// and reports done/err to the granted requester. The grant stays asserted
// for the whole transaction, because it also selects the BRAM read-port owner.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no transaction; all outputs low; arbitrate on any req_i
//   ISSUE   | grant held, read_stb_o high for this one cycle
//   WAIT    | waiting for read_done_stb_i; timeout counter running
//   RELEASE | done/err pulse visible; grant drops and pointer moves on exit
//
// Ports
//   wb_clk_i         system clock, rising edge
//   wb_rst_i         asynchronous active-high reset
//   req_i[1:0]       level requests (0 = boot loader, 1 = Wishbone fetch)
//   addr0_i/addr1_i  flash byte address of each requester
//   gnt_o[1:0]       one-hot grant, held ISSUE..RELEASE
//   done_o[1:0]      one-cycle completion pulse to the granted requester
//   err_o[1:0]       one-cycle timeout pulse to the granted requester
//   read_addr_o      block-aligned address to the flash controller
//   read_stb_o       one-cycle read-start strobe
//   read_done_stb_i  block-complete pulse from the flash controller
//   abort_o          one-cycle pulse forcing the flash controller to idle
//   busy_o           high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module spi_flash_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 400000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [1:0]  req_i,
    input  logic [23:0] addr0_i,
    input  logic [23:0] addr1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    output logic [23:0] read_addr_o,
    output logic        read_stb_o,
    input  logic        read_done_stb_i,
    output logic        abort_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W   = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;      // 1: requester 1 wins a tie
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic [23:0]        addr_q, addr_d;
    logic               stb_q, stb_d;
    logic               abort_q, abort_d;
    logic               busy_q, busy_d;

    logic [1:0]         pick;
    logic [23:0]        pick_addr;
    logic               done_hit;
    logic               tmo_hit;

    // Arbitration: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        pick = req_i;
        if (req_i == 2'b11) begin
            pick = ptr_q ? 2'b10 : 2'b01;
        end
        pick_addr = pick[1] ? addr1_i : addr0_i;
    end

    // Completion beats timeout when both land in the same WAIT cycle.
    assign done_hit = (state_q == ST_WAIT) && read_done_stb_i;
    assign tmo_hit  = (state_q == ST_WAIT) && !read_done_stb_i && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            addr_q  <= '0;
            stb_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            stb_q   <= stb_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. The counter sits at zero through IDLE and ISSUE and
    // then counts up once per cycle, so during WAIT it holds the number of
    // cycles elapsed since the read strobe.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_i != 2'b00) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (done_hit || tmo_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                ptr_d   = gnt_q[0];
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: every output is computed one cycle ahead and registered.
    always_comb begin
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        done_d  = '0;
        err_d   = '0;
        stb_d   = 1'b0;
        abort_d = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d  = pick;
                    addr_d = {pick_addr[23:10], 10'b0};
                    stb_d  = 1'b1;
                end else begin
                    gnt_d  = '0;
                    addr_d = '0;
                end
            end
            ST_ISSUE: begin
            end
            ST_WAIT: begin
                if (done_hit) begin
                    done_d = gnt_q;
                end else if (tmo_hit) begin
                    err_d   = gnt_q;
                    abort_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                gnt_d  = '0;
                addr_d = '0;
            end
            default: begin
                gnt_d  = '0;
                addr_d = '0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign read_addr_o = addr_q;
    assign read_stb_o  = stb_q;
    assign abort_o     = abort_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
module tb_spi_flash_arbiter;

    localparam int TMO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [1:0]  req_i = '0;
    logic [23:0] addr0_i = '0;
    logic [23:0] addr1_i = '0;
    logic [1:0]  gnt_o;
    logic [1:0]  done_o;
    logic [1:0]  err_o;
    logic [23:0] read_addr_o;
    logic        read_stb_o;
    logic        read_done_stb_i = 1'b0;
    logic        abort_o;
    logic        busy_o;

    spi_flash_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .req_i           (req_i),
        .addr0_i         (addr0_i),
        .addr1_i         (addr1_i),
        .gnt_o           (gnt_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .read_addr_o     (read_addr_o),
        .read_stb_o      (read_stb_o),
        .read_done_stb_i (read_done_stb_i),
        .abort_o         (abort_o),
        .busy_o          (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  gnt;
        logic [23:0] addr;
    } issue_t;

    typedef struct {
        logic [1:0] done;
        logic [1:0] err;
        logic       abort;
        int         lat;
    } cpl_t;

    issue_t iss_q[$];
    cpl_t   cpl_q[$];

    // Reference model state: which requester wins when both ask.
    bit favour1 = 1'b0;

    // ---------------------------------------------------------------- monitor
    int          cyc = 0;
    int          stb_cyc = 0;
    logic [1:0]  cur_gnt = '0;
    logic [23:0] cur_addr = '0;
    issue_t      mi;
    cpl_t        mc;

    always @(negedge wb_clk_i) begin
        cyc++;
        if (!wb_rst_i) begin
            check("gnt_onehot", 64'($countones(gnt_o) <= 1), 64'd1);
            check("pulse_to_granted", 64'((done_o | err_o) & ~gnt_o), 64'd0);
            if (!busy_o) begin
                check("idle_outputs",
                      64'({gnt_o, done_o, err_o, read_stb_o, abort_o, read_addr_o}), 64'd0);
            end
            if (read_stb_o) begin
                check("stb_expected", 64'(iss_q.size() != 0), 64'd1);
                if (iss_q.size() != 0) begin
                    mi = iss_q.pop_front();
                    check("grant", 64'(gnt_o), 64'(mi.gnt));
                    check("read_addr", 64'(read_addr_o), 64'(mi.addr));
                    check("busy_issue", 64'(busy_o), 64'd1);
                    cur_gnt  = mi.gnt;
                    cur_addr = mi.addr;
                    stb_cyc  = cyc;
                end
            end else if (busy_o) begin
                check("gnt_hold", 64'(gnt_o), 64'(cur_gnt));
                check("addr_hold", 64'(read_addr_o), 64'(cur_addr));
            end
            if ((done_o | err_o) != 2'b00 || abort_o) begin
                check("cpl_expected", 64'(cpl_q.size() != 0), 64'd1);
                if (cpl_q.size() != 0) begin
                    mc = cpl_q.pop_front();
                    check("done", 64'(done_o), 64'(mc.done));
                    check("err", 64'(err_o), 64'(mc.err));
                    check("abort", 64'(abort_o), 64'(mc.abort));
                    check("latency", 64'(cyc - stb_cyc), 64'(mc.lat));
                end
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge wb_clk_i);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    // d: cycle after the strobe in which read_done_stb_i is pulsed (0 = never).
    task automatic do_txn(input logic [1:0] req, input logic [23:0] a0, input logic [23:0] a1,
                          input int d, input bit drop, input bit stray, input bit keep);
        issue_t ie;
        cpl_t   ce;
        bit     ok;
        bit     in_time;
        wait_idle();
        read_done_stb_i = 1'b0;
        req_i   = req;
        addr0_i = a0;
        addr1_i = a1;
        ie.gnt  = (req == 2'b11) ? (favour1 ? 2'b10 : 2'b01) : req;
        ie.addr = (ie.gnt[1] ? a1 : a0) & 24'hFFFC00;
        iss_q.push_back(ie);
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            if (read_stb_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("stb_seen", 64'(ok), 64'd1);
        if (!ok) begin
            req_i = '0;
            return;
        end
        favour1  = ie.gnt[0];
        in_time  = (d >= 1) && (d <= TMO - 1);
        ce.done  = in_time ? ie.gnt : 2'b00;
        ce.err   = in_time ? 2'b00 : ie.gnt;
        ce.abort = !in_time;
        ce.lat   = in_time ? d + 1 : TMO;
        cpl_q.push_back(ce);
        if (drop) req_i = '0;
        addr0_i = 24'($urandom);
        addr1_i = 24'($urandom);
        read_done_stb_i = stray;
        ok = 1'b0;
        for (int k = 1; k <= TMO + 4; k++) begin
            @(negedge wb_clk_i);
            if ((done_o | err_o) != 2'b00) begin
                ok = 1'b1;
                break;
            end
            read_done_stb_i = (k == d);
        end
        check("cpl_seen", 64'(ok), 64'd1);
        read_done_stb_i = 1'b0;
        if (!keep) begin
            req_i = '0;
            if (stray) begin
                read_done_stb_i = 1'b1;
                @(negedge wb_clk_i);
                read_done_stb_i = 1'b0;
            end
        end
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        #1;
        check("reset_outputs",
              64'({gnt_o, done_o, err_o, read_stb_o, abort_o, busy_o, read_addr_o}), 64'd0);
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // both requesting continuously: 0,1,0,1
        for (int t = 0; t < 4; t++) begin
            do_txn(2'b11, 24'($urandom), 24'($urandom), 2 + t, 1'b0, 1'b0, t < 3);
        end

        // single requester, done 10 cycles after the strobe
        do_txn(2'b01, 24'h012345, 24'h0, 10, 1'b0, 1'b0, 1'b0);

        // timeout, no completion pulse
        do_txn(2'b10, 24'($urandom), 24'($urandom), 0, 1'b0, 1'b0, 1'b0);

        // completion in the same cycle as the timeout condition
        do_txn(2'b01, 24'($urandom), 24'($urandom), TMO - 1, 1'b0, 1'b0, 1'b0);

        // one cycle too late: timeout wins
        do_txn(2'b10, 24'($urandom), 24'($urandom), TMO, 1'b0, 1'b0, 1'b0);

        // stray completion pulse while idle
        wait_idle();
        read_done_stb_i = 1'b1;
        @(negedge wb_clk_i);
        read_done_stb_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            check("stray_busy", 64'(busy_o), 64'd0);
            check("stray_done", 64'(done_o), 64'd0);
        end

        // asynchronous reset in the middle of WAIT
        wait_idle();
        req_i   = 2'b01;
        addr0_i = 24'($urandom);
        mi.gnt  = 2'b01;
        mi.addr = addr0_i & 24'hFFFC00;
        iss_q.push_back(mi);
        @(negedge wb_clk_i);
        check("rst_txn_stb", 64'(read_stb_o), 64'd1);
        repeat (5) @(negedge wb_clk_i);
        check("rst_txn_busy", 64'(busy_o), 64'd1);
        @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("rst_async",
              64'({gnt_o, done_o, err_o, read_stb_o, abort_o, busy_o, read_addr_o}), 64'd0);
        req_i   = '0;
        favour1 = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        do_txn(2'b10, 24'($urandom), 24'($urandom), 4, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [1:0] rq;
            int         d;
            rq = 2'(1 + $urandom_range(0, 2));
            d  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TMO + 3));
            do_txn(rq, 24'($urandom), 24'($urandom), d,
                   1'($urandom), 1'($urandom), (t == 39) ? 1'b0 : 1'($urandom));
        end

        repeat (6) @(negedge wb_clk_i);
        check("issue_queue_empty", 64'(iss_q.size()), 64'd0);
        check("cpl_queue_empty", 64'(cpl_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d",
                 n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
